// File: rtl/calculation_unit_exponent_arbiter.sv
// calculation_unit_exponent_arbiter
//   Round-robin arbiter that shares one exponent-difference stage between
//   NUM_REQ requesters (e.g. add/sub alignment and compare paths). The
//   winner's sign-extended difference a-b is registered together with the
//   winner's index. The result is held under downstream backpressure.
//
//   Optional build macro CALCULATION_UNIT_EXPONENT_ARBITER_STALL_COUNTER_EN
//   adds a saturating 16-bit count of stalled cycles (stall_count).
//
// Ports
//   clk, reset          clock, async active-high reset
//   req_valid/req_ready per-requester handshake (req_ready at most one-hot)
//   req_exponent_a/b    packed 8-bit exponents, requester i at [8i+7:8i]
//   result_valid/ready  output handshake
//   result_difference   10-bit ext(a)-ext(b), modulo 2^10
//   result_negative     result_difference[9]
//   result_id           index of the requester that produced the result
//   stall_count         (optional) cycles with result_valid & !result_ready

// Per-lane difference: sign-extend both exponents to 10 bits and subtract.
module calculation_unit_exponent_arbiter_lane (
  input  logic [7:0] exp_a_i,
  input  logic [7:0] exp_b_i,
  output logic [9:0] diff_o
);
  logic [9:0] ext_a, ext_b;
  assign ext_a  = {{2{exp_a_i[7]}}, exp_a_i};
  assign ext_b  = {{2{exp_b_i[7]}}, exp_b_i};
  assign diff_o = ext_a - ext_b;
endmodule

module calculation_unit_exponent_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*8-1:0]  req_exponent_a,
  input  logic [NUM_REQ*8-1:0]  req_exponent_b,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [9:0]            result_difference,
  output logic                  result_negative,
  output logic [ID_WIDTH-1:0]   result_id
`ifdef CALCULATION_UNIT_EXPONENT_ARBITER_STALL_COUNTER_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  // Every lane computes its difference in parallel; the grant only picks one.
  logic [NUM_REQ-1:0][9:0] lane_diff;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    calculation_unit_exponent_arbiter_lane u_lane (
      .exp_a_i (req_exponent_a[8*i +: 8]),
      .exp_b_i (req_exponent_b[8*i +: 8]),
      .diff_o  (lane_diff[i])
    );
  end

  logic                valid_q;
  logic [9:0]          diff_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                gnt_found;
  logic                can_accept;
  logic                xfer;

  // Rotating priority: first valid requester at or after rr_ptr wins.
  always_comb begin
    int j;
    logic [ID_WIDTH-1:0] idx;
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    j         = 0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = ID_WIDTH'(j);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found  = 1'b1;
        gnt_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign can_accept = !valid_q || result_ready;
  assign xfer       = can_accept && gnt_found;
  assign req_ready  = (reset || !can_accept) ? '0 : grant;
  assign rr_ptr_d   = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      diff_q   <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else if (xfer) begin
      valid_q  <= 1'b1;
      diff_q   <= lane_diff[gnt_idx];
      id_q     <= gnt_idx;
      rr_ptr_q <= rr_ptr_d;
    end else if (result_ready) begin
      // Drain: data registers keep their last value.
      valid_q  <= 1'b0;
    end
  end

  assign result_valid      = valid_q;
  assign result_difference = diff_q;
  assign result_negative   = diff_q[9];
  assign result_id         = id_q;

`ifdef CALCULATION_UNIT_EXPONENT_ARBITER_STALL_COUNTER_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !result_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
